// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the MIPS32 pipeline hazard controller.
package mips_pipe_pkg;

  localparam int unsigned REG_W           = 5;
  localparam int unsigned MULDIV_LAT_DEF  = 32;
  localparam int unsigned MEM_TIMEOUT_DEF = 255;
  localparam int unsigned CNT_W_DEF       = 8;

  localparam logic [REG_W-1:0] ZERO_REG = '0;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_e;

  typedef struct packed {
    logic stall_pc;
    logic stall_ifid;
    logic stall_idex;
    logic stall_exmem;
    logic stall_memwb;
    logic flush_ifid;
    logic flush_idex;
  } hazard_ctl_t;

  // A load into $zero never creates a dependency.
  function automatic logic load_use_hit(input logic [REG_W-1:0] ex_rt,
                                        input logic [REG_W-1:0] id_rs,
                                        input logic [REG_W-1:0] id_rt,
                                        input logic             uses_rt);
    return (ex_rt != ZERO_REG) &&
           ((ex_rt == id_rs) || (uses_rt && (ex_rt == id_rt)));
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Datapath <-> hazard controller signal bundle.
interface pipeline_hazard_ctrl_if;

  logic [mips_pipe_pkg::REG_W-1:0] id_rs;
  logic [mips_pipe_pkg::REG_W-1:0] id_rt;
  logic [mips_pipe_pkg::REG_W-1:0] ex_rt;
  logic id_uses_rt;
  logic id_hilo_use;
  logic ex_memread;
  logic ex_branch_taken;
  logic ex_muldiv_start;
  logic mem_req;
  logic mem_ready;

  logic stall_pc;
  logic stall_ifid;
  logic stall_idex;
  logic stall_exmem;
  logic stall_memwb;
  logic flush_ifid;
  logic flush_idex;
  logic muldiv_busy;
  logic err_mem_timeout;

  // Datapath side: supplies hazard sources, consumes stall/flush selects.
  modport master (
    output id_rs, id_rt, ex_rt, id_uses_rt, id_hilo_use, ex_memread,
           ex_branch_taken, ex_muldiv_start, mem_req, mem_ready,
    input  stall_pc, stall_ifid, stall_idex, stall_exmem, stall_memwb,
           flush_ifid, flush_idex, muldiv_busy, err_mem_timeout
  );

  modport slave (
    input  id_rs, id_rt, ex_rt, id_uses_rt, id_hilo_use, ex_memread,
           ex_branch_taken, ex_muldiv_start, mem_req, mem_ready,
    output stall_pc, stall_ifid, stall_idex, stall_exmem, stall_memwb,
           flush_ifid, flush_idex, muldiv_busy, err_mem_timeout
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_muldiv_busy_counter.sv
// Occupancy counter for the multi-cycle mul/div unit.
module muldiv_busy_counter #(
  parameter int unsigned LAT   = 32,
  parameter int unsigned CNT_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  input  logic hold_i,
  output logic busy_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // The unit keeps counting through a pipeline freeze; only the start is held off.
  always_comb begin
    cnt_d = cnt_q;
    if (start_i && !hold_i) begin
      cnt_d = CNT_W'(LAT - 1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage MIPS32 pipeline.
module pipeline_hazard_ctrl
  import mips_pipe_pkg::*;
#(
  parameter int unsigned MULDIV_LAT  = MULDIV_LAT_DEF,
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pipeline_hazard_ctrl_if.slave  bus
);

  mem_state_e       state_q;
  mem_state_e       state_d;
  logic [CNT_W-1:0] wait_cnt_q;
  logic [CNT_W-1:0] wait_cnt_d;
  logic             err_q;
  logic             err_d;

  logic        freeze_c;
  logic        load_use_c;
  logic        hilo_c;
  logic        md_busy;
  hazard_ctl_t ctl_c;

  muldiv_busy_counter #(
    .LAT   (MULDIV_LAT),
    .CNT_W (CNT_W)
  ) u_muldiv_busy_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (bus.ex_muldiv_start),
    .hold_i  (freeze_c),
    .busy_o  (md_busy)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

  // Memory-wait FSM: freeze is Mealy so the first unready cycle already holds.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q;
    freeze_c   = 1'b0;
    case (state_q)
      RUN: begin
        if (bus.mem_req && !bus.mem_ready) begin
          freeze_c   = 1'b1;
          state_d    = MEM_WAIT;
          wait_cnt_d = CNT_W'(1);
        end
      end
      MEM_WAIT: begin
        freeze_c = !bus.mem_ready;
        if (wait_cnt_q == CNT_W'(MEM_TIMEOUT)) begin
          err_d = 1'b1;
        end
        if (bus.mem_ready) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q != '1) begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // Priority: freeze, then taken branch (ID is wrong-path), then bubble insertion.
  always_comb begin
    ctl_c      = '0;
    load_use_c = bus.ex_memread &&
                 load_use_hit(bus.ex_rt, bus.id_rs, bus.id_rt, bus.id_uses_rt);
    hilo_c     = md_busy && bus.id_hilo_use;
    if (freeze_c) begin
      ctl_c.stall_pc    = 1'b1;
      ctl_c.stall_ifid  = 1'b1;
      ctl_c.stall_idex  = 1'b1;
      ctl_c.stall_exmem = 1'b1;
      ctl_c.stall_memwb = 1'b1;
    end else if (bus.ex_branch_taken) begin
      ctl_c.flush_ifid = 1'b1;
      ctl_c.flush_idex = 1'b1;
    end else if (load_use_c || hilo_c) begin
      ctl_c.stall_pc   = 1'b1;
      ctl_c.stall_ifid = 1'b1;
      ctl_c.flush_idex = 1'b1;
    end
  end

  // Outputs are forced low for as long as reset is asserted.
  assign bus.stall_pc        = rst_n & ctl_c.stall_pc;
  assign bus.stall_ifid      = rst_n & ctl_c.stall_ifid;
  assign bus.stall_idex      = rst_n & ctl_c.stall_idex;
  assign bus.stall_exmem     = rst_n & ctl_c.stall_exmem;
  assign bus.stall_memwb     = rst_n & ctl_c.stall_memwb;
  assign bus.flush_ifid      = rst_n & ctl_c.flush_ifid;
  assign bus.flush_idex      = rst_n & ctl_c.flush_idex;
  assign bus.muldiv_busy     = rst_n & md_busy;
  assign bus.err_mem_timeout = rst_n & err_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scenario bench for pipeline_hazard_ctrl (MULDIV_LAT=32, MEM_TIMEOUT=4).
module tb_pipeline_hazard_ctrl;

  logic clk;
  logic rst_n;

  pipeline_hazard_ctrl_if bus ();

  pipeline_hazard_ctrl #(
    .MULDIV_LAT  (32),
    .MEM_TIMEOUT (4),
    .CNT_W       (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control vector order: {stall_pc, stall_ifid, stall_idex, stall_exmem, stall_memwb, flush_ifid, flush_idex}
  localparam logic [6:0] C_NONE = 7'b0000000;
  localparam logic [6:0] C_FRZ  = 7'b1111100;
  localparam logic [6:0] C_BR   = 7'b0000011;
  localparam logic [6:0] C_BUB  = 7'b1100001;

  // Stimulus flags: {uses_rt, hilo, memread, branch, muldiv_start, mem_req, mem_ready}
  localparam logic [6:0] F_USE  = 7'b1000000;
  localparam logic [6:0] F_HILO = 7'b0100000;
  localparam logic [6:0] F_LD   = 7'b0010000;
  localparam logic [6:0] F_BR   = 7'b0001000;
  localparam logic [6:0] F_MD   = 7'b0000100;
  localparam logic [6:0] F_REQ  = 7'b0000010;
  localparam logic [6:0] F_RDY  = 7'b0000001;

  logic [8:0] sb[$];
  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [8:0] outs();
    return {bus.stall_pc, bus.stall_ifid, bus.stall_idex, bus.stall_exmem,
            bus.stall_memwb, bus.flush_ifid, bus.flush_idex,
            bus.muldiv_busy, bus.err_mem_timeout};
  endfunction

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] ert, input logic [6:0] f);
    bus.id_rs           = rs;
    bus.id_rt           = rt;
    bus.ex_rt           = ert;
    bus.id_uses_rt      = f[6];
    bus.id_hilo_use     = f[5];
    bus.ex_memread      = f[4];
    bus.ex_branch_taken = f[3];
    bus.ex_muldiv_start = f[2];
    bus.mem_req         = f[1];
    bus.mem_ready       = f[0];
  endtask

  task automatic test_reset();
    logic [8:0] got, exp;
    rst_n = 1'b0;
    drive(5'd8, 5'd0, 5'd8, F_LD | F_BR | F_REQ | F_HILO);
    sb.push_back(9'b0);
    #3;
    got = outs(); exp = sb.pop_front(); n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL reset_hold got=%b exp=%b", got, exp); end
    @(negedge clk);
    rst_n = 1'b1;
    drive(5'd0, 5'd0, 5'd0, 7'b0);
    @(posedge clk); #1;
    for (int c = 0; c < 2; c++) begin
      if (c == 0) drive(5'd0, 5'd0, 5'd0, 7'b0);
      else        drive(5'd0, 5'd0, 5'd0, F_REQ | F_RDY);
      sb.push_back({C_NONE, 2'b00});
      @(negedge clk);
      got = outs(); exp = sb.pop_front(); n_cmp++;
      if (got !== exp) begin n_err++; $display("FAIL reset_release c%0d got=%b exp=%b", c, got, exp); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    logic [8:0] got, exp;
    for (int c = 0; c < 6; c++) begin
      case (c)
        0: begin drive(5'd8, 5'd0, 5'd8, F_LD);         sb.push_back({C_BUB,  2'b00}); end
        1: begin drive(5'd8, 5'd0, 5'd8, 7'b0);         sb.push_back({C_NONE, 2'b00}); end
        2: begin drive(5'd0, 5'd0, 5'd0, F_LD | F_USE); sb.push_back({C_NONE, 2'b00}); end
        3: begin drive(5'd3, 5'd8, 5'd8, F_LD);         sb.push_back({C_NONE, 2'b00}); end
        4: begin drive(5'd3, 5'd8, 5'd8, F_LD | F_USE); sb.push_back({C_BUB,  2'b00}); end
        default: begin drive(5'd3, 5'd9, 5'd8, F_LD | F_USE); sb.push_back({C_NONE, 2'b00}); end
      endcase
      @(negedge clk);
      got = outs(); exp = sb.pop_front(); n_cmp++;
      if (got !== exp) begin n_err++; $display("FAIL load_use c%0d got=%b exp=%b", c, got, exp); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch();
    logic [8:0] got, exp;
    for (int c = 0; c < 3; c++) begin
      case (c)
        0: begin drive(5'd8, 5'd0, 5'd8, F_LD | F_BR);  sb.push_back({C_BR,   2'b00}); end
        1: begin drive(5'd0, 5'd0, 5'd0, F_BR | F_HILO); sb.push_back({C_BR,  2'b00}); end
        default: begin drive(5'd0, 5'd0, 5'd0, 7'b0);    sb.push_back({C_NONE, 2'b00}); end
      endcase
      @(negedge clk);
      got = outs(); exp = sb.pop_front(); n_cmp++;
      if (got !== exp) begin n_err++; $display("FAIL branch c%0d got=%b exp=%b", c, got, exp); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_muldiv();
    logic [8:0] got, exp;
    for (int c = 0; c < 34; c++) begin
      if (c == 0) begin
        drive(5'd0, 5'd0, 5'd0, F_MD | F_HILO); sb.push_back({C_NONE, 2'b00});
      end else if (c <= 31) begin
        drive(5'd0, 5'd0, 5'd0, F_HILO);        sb.push_back({C_BUB, 2'b10});
      end else begin
        drive(5'd0, 5'd0, 5'd0, F_HILO);        sb.push_back({C_NONE, 2'b00});
      end
      @(negedge clk);
      got = outs(); exp = sb.pop_front(); n_cmp++;
      if (got !== exp) begin n_err++; $display("FAIL muldiv c%0d got=%b exp=%b", c, got, exp); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_freeze_start();
    logic [8:0] got, exp;
    for (int c = 0; c < 3; c++) begin
      case (c)
        0: begin drive(5'd0, 5'd0, 5'd0, F_MD | F_REQ);  sb.push_back({C_FRZ,  2'b00}); end
        1: begin drive(5'd0, 5'd0, 5'd0, F_REQ | F_RDY); sb.push_back({C_NONE, 2'b00}); end
        default: begin drive(5'd0, 5'd0, 5'd0, 7'b0);    sb.push_back({C_NONE, 2'b00}); end
      endcase
      @(negedge clk);
      got = outs(); exp = sb.pop_front(); n_cmp++;
      if (got !== exp) begin n_err++; $display("FAIL freeze_start c%0d got=%b exp=%b", c, got, exp); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mem_wait();
    logic [8:0] got, exp;
    for (int c = 0; c < 7; c++) begin
      case (c)
        0: begin drive(5'd0, 5'd0, 5'd0, F_REQ | F_RDY);        sb.push_back({C_NONE, 2'b00}); end
        1: begin drive(5'd0, 5'd0, 5'd0, 7'b0);                 sb.push_back({C_NONE, 2'b00}); end
        2: begin drive(5'd0, 5'd0, 5'd0, F_REQ);                sb.push_back({C_FRZ,  2'b00}); end
        3: begin drive(5'd8, 5'd0, 5'd8, F_REQ | F_BR | F_LD);  sb.push_back({C_FRZ,  2'b00}); end
        4: begin drive(5'd0, 5'd0, 5'd0, F_REQ | F_BR);         sb.push_back({C_FRZ,  2'b00}); end
        5: begin drive(5'd0, 5'd0, 5'd0, F_REQ | F_RDY | F_BR); sb.push_back({C_BR,   2'b00}); end
        default: begin drive(5'd0, 5'd0, 5'd0, 7'b0);           sb.push_back({C_NONE, 2'b00}); end
      endcase
      @(negedge clk);
      got = outs(); exp = sb.pop_front(); n_cmp++;
      if (got !== exp) begin n_err++; $display("FAIL mem_wait c%0d got=%b exp=%b", c, got, exp); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    logic [8:0] got, exp;
    for (int c = 0; c < 22; c++) begin
      if (c == 0) begin
        drive(5'd0, 5'd0, 5'd0, F_MD);  sb.push_back({C_NONE, 2'b00});
      end else if (c <= 20) begin
        drive(5'd0, 5'd0, 5'd0, 7'b0);  sb.push_back({C_NONE, 2'b10});
      end else begin
        drive(5'd0, 5'd0, 5'd0, F_REQ); sb.push_back({C_FRZ, 2'b10});
      end
      @(negedge clk);
      got = outs(); exp = sb.pop_front(); n_cmp++;
      if (got !== exp) begin n_err++; $display("FAIL reset_mid_pre c%0d got=%b exp=%b", c, got, exp); end
      @(posedge clk); #1;
    end
    // Now in MEM_WAIT with the mul/div counter at 10.
    drive(5'd8, 5'd0, 5'd8, F_REQ | F_LD | F_BR | F_HILO);
    sb.push_back({C_FRZ, 2'b10});
    #1;
    got = outs(); exp = sb.pop_front(); n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL reset_mid_wait got=%b exp=%b", got, exp); end
    rst_n = 1'b0;
    sb.push_back(9'b0);
    #1;
    got = outs(); exp = sb.pop_front(); n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL reset_mid_async got=%b exp=%b", got, exp); end
    @(negedge clk);
    rst_n = 1'b1;
    drive(5'd0, 5'd0, 5'd0, 7'b0);
    @(posedge clk); #1;
    for (int c = 0; c < 2; c++) begin
      if (c == 0) drive(5'd0, 5'd0, 5'd0, 7'b0);
      else        drive(5'd0, 5'd0, 5'd0, F_HILO);
      sb.push_back({C_NONE, 2'b00});
      @(negedge clk);
      got = outs(); exp = sb.pop_front(); n_cmp++;
      if (got !== exp) begin n_err++; $display("FAIL reset_mid_post c%0d got=%b exp=%b", c, got, exp); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout();
    logic [8:0] got, exp;
    for (int c = 0; c < 8; c++) begin
      if (c <= 4) begin
        drive(5'd0, 5'd0, 5'd0, F_REQ);         sb.push_back({C_FRZ, 2'b00});
      end else if (c == 5) begin
        drive(5'd0, 5'd0, 5'd0, F_REQ);         sb.push_back({C_FRZ, 2'b01});
      end else if (c == 6) begin
        drive(5'd0, 5'd0, 5'd0, F_REQ | F_RDY); sb.push_back({C_NONE, 2'b01});
      end else begin
        drive(5'd0, 5'd0, 5'd0, 7'b0);          sb.push_back({C_NONE, 2'b01});
      end
      @(negedge clk);
      got = outs(); exp = sb.pop_front(); n_cmp++;
      if (got !== exp) begin n_err++; $display("FAIL timeout c%0d got=%b exp=%b", c, got, exp); end
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    drive(5'd0, 5'd0, 5'd0, 7'b0);
    sb.push_back({C_NONE, 2'b00});
    @(negedge clk);
    got = outs(); exp = sb.pop_front(); n_cmp++;
    if (got !== exp) begin n_err++; $display("FAIL timeout_cleared got=%b exp=%b", got, exp); end
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired after %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_muldiv();
    test_freeze_start();
    test_mem_wait();
    test_reset_mid();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage MIPS32 pipeline.
- Drives the per-stage `stall` inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC register.
- Drives the flush (bubble-insert) selects the datapath uses to force zero into IF/ID and ID/EX.
- Detects load-use hazards, taken branches, multi-cycle mul/div occupancy and data-memory wait states.
- Runs a memory-wait FSM with timeout detection.

Parameters:
MULDIV_LAT, 32, cycles the mul/div unit stays busy after a start (>=2)
MEM_TIMEOUT, 255, max consecutive MEM_WAIT cycles before err_mem_timeout sets
CNT_W, 8, width of the internal counters (must hold both MULDIV_LAT and MEM_TIMEOUT)

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_rs  in  5  rs field of the instruction in ID
id_rt  in  5  rt field of the instruction in ID
id_uses_rt  in  1  ID instruction reads rt as a source
id_hilo_use  in  1  ID instruction is mfhi/mflo/mult/div
ex_memread  in  1  EX instruction is a load
ex_rt  in  5  load destination register in EX
ex_branch_taken  in  1  branch/jump in EX resolved taken
ex_muldiv_start  in  1  mult/div instruction in EX
mem_req  in  1  MEM stage issuing a data-memory access
mem_ready  in  1  data memory completes the access this cycle
stall_pc  out  1  hold PC
stall_ifid  out  1  hold IF/ID register
stall_idex  out  1  hold ID/EX register
stall_exmem  out  1  hold EX/MEM register
stall_memwb  out  1  hold MEM/WB register
flush_ifid  out  1  load NOP into IF/ID
flush_idex  out  1  load NOP (bubble) into ID/EX
muldiv_busy  out  1  mul/div unit occupied
err_mem_timeout  out  1  sticky memory-timeout flag

Behaviour:
- Reset (rst_n=0, asynchronous):
  - FSM=RUN, md_cnt=0, wait_cnt=0, err_mem_timeout=0.
  - All combinational outputs evaluate to 0 while in reset.
- Memory FSM states:
  - RUN:
    - mem_req & !mem_ready -> freeze asserted this cycle (Mealy); next state MEM_WAIT; wait_cnt=1.
    - mem_req & mem_ready -> no freeze; stay in RUN.
  - MEM_WAIT:
    - freeze = !mem_ready.
    - mem_ready=1 -> next state RUN; wait_cnt=0.
    - otherwise wait_cnt increments, saturating.
    - wait_cnt==MEM_TIMEOUT -> err_mem_timeout=1 (sticky until reset); the FSM stays in MEM_WAIT.
- Freeze: all five stall outputs =1; both flush outputs forced 0. A frozen EX register re-presents the branch/load on release.
- Branch (no freeze, ex_branch_taken=1):
  - flush_ifid=1, flush_idex=1, all stalls 0.
  - Branch overrides load-use and hilo stalls, since the ID instruction is wrong-path.
- Load-use (no freeze, no branch):
  - Hazard = ex_memread & ex_rt!=0 & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)).
  - Response: stall_pc=1, stall_ifid=1, flush_idex=1; exactly one bubble per hazard.
- Mul/div counter:
  - On ex_muldiv_start & !freeze: md_cnt loads MULDIV_LAT-1.
  - Otherwise, if md_cnt!=0, it decrements every cycle, freeze included (the unit runs independently).
  - muldiv_busy = (md_cnt!=0).
  - A start while busy reloads the counter. This cannot happen in legal flow because of the hilo stall.
- Hilo stall (no freeze, no branch):
  - Condition: muldiv_busy & id_hilo_use.
  - Response: same as load-use (stall_pc, stall_ifid, flush_idex).
  - Load-use and hilo stall together produce the same single response.
- stall_idex, stall_exmem and stall_memwb assert only on freeze.
- Outputs are combinational from registered state plus inputs; no output latency. State updates on the rising clk edge.

Decomposition:
- Package mips_pipe_pkg:
  - REG_W=5
  - the memory FSM state enum {RUN, MEM_WAIT}
  - default MULDIV_LAT and MEM_TIMEOUT constants
  - the zero-register constant
- One natural sub-module: muldiv_busy_counter. It holds the load/decrement counter and produces muldiv_busy, and takes start, hold and clk/rst_n.

Test Plan:
- Reset: rst_n low mid-MEM_WAIT with md_cnt=10 -> all outputs 0 immediately. After release: FSM=RUN, muldiv_busy=0, err=0.
- Load-use: ex_memread=1, ex_rt=8, id_rs=8 -> one cycle of stall_pc=stall_ifid=flush_idex=1. With ex_rt=0, or id_rt=8 and id_uses_rt=0 -> no stall.
- Branch with simultaneous load-use: ex_branch_taken=1 and the hazard from the load-use scenario -> flush_ifid=flush_idex=1, stall_pc=0.
- Mul/div: ex_muldiv_start pulse, MULDIV_LAT=32 -> muldiv_busy high for exactly 31 cycles. id_hilo_use=1 throughout -> 31 bubbles, then release.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles then 1 -> all stalls high for 3 cycles, low on the ready cycle. An ex_branch_taken during the freeze yields no flush until release.
- Timeout: MEM_TIMEOUT=4, mem_ready held 0 -> err_mem_timeout rises after the 4th MEM_WAIT cycle and stays high after mem_ready=1 until rst_n.
